half_subtractor: RTL and testbench
==================================

HALF_SUBTRACTOR -- requirements
Module: half_subtractor

Interface
REQ-001 Parameter: WIDTH, default 1, operand/difference width in bits (legal 1..32).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert and active-low; the only reset.
REQ-004 Port: A  input  WIDTH  minuend.
REQ-005 Port: B  input  WIDTH  subtrahend.
REQ-006 Port: in_valid  input  1  A/B qualify this cycle.
REQ-007 Port: D  output  WIDTH  registered difference, (A - B) mod 2^WIDTH.
REQ-008 Port: Br  output  1  registered borrow-out, 1 when A < B (unsigned).
REQ-009 Port: out_valid  output  1  D/Br hold a fresh result this cycle.
REQ-010 Port: borrow_cnt  output  16  borrow-event count; present only with HALF_SUBTRACTOR_BORROW_CNT_EN.

Function
REQ-011 Result SHALL be combinational from A, B: D = A - B truncated to WIDTH, Br = (A < B); for WIDTH=1 this reduces to D = A xor B, Br = (not A) and B.
REQ-012 When in_valid=1 at a rising clk edge, D and Br SHALL load the result of that cycle's A/B; latency exactly 1 cycle.
REQ-013 When in_valid=0 at an edge, D and Br SHALL hold their previous values.
REQ-014 out_valid SHALL equal in_valid delayed by one cycle; back-to-back valid inputs give one result per cycle with no bubbles.
REQ-015 No backpressure: results are never stalled or dropped.
REQ-016 A = B SHALL give D = 0, Br = 0; A = 0, B = 2^WIDTH-1 SHALL give D = 1, Br = 1 (wrap-around).
REQ-017 X/unknown values on A/B while in_valid=0 SHALL NOT affect D, Br or out_valid.

Reset
REQ-018 rst_n=0 SHALL immediately, without waiting for clk, force D=0, Br=0, out_valid=0 and borrow_cnt=0.
REQ-019 While rst_n=0, in_valid SHALL be ignored; a valid input at the edge on which rst_n rises is not captured.
REQ-020 Reset asserted mid-stream SHALL discard the in-flight result; the first out_valid after release comes 1 cycle after the first accepted in_valid.

Configuration
REQ-021 Macro HALF_SUBTRACTOR_BORROW_CNT_EN defined: borrow_cnt port exists and SHALL increment by 1 on every edge with in_valid=1 and A < B, saturating at 16'hFFFF.
REQ-022 Macro undefined: the borrow_cnt port and counter logic SHALL be absent; all other behaviour is identical.

Structure
REQ-023 Package half_subtractor_pkg SHALL hold the default-width constant, the counter width (16) and the counter saturation value.
REQ-024 Combinational difference/borrow logic SHALL be one sub-module, half_subtractor_core (no clock, no reset), instantiated once; registers, valid pipe and counter live in the top.

Verification
REQ-025 WIDTH=1, apply A/B = 00, 01, 10, 11 one per cycle with in_valid=1 -> one cycle later D/Br = 0/0, 1/1, 1/0, 0/0, out_valid=1 each cycle.
REQ-026 WIDTH=8, A=8'h05, B=8'h07 -> D=8'hFE, Br=1; A=8'h80, B=8'h80 -> D=8'h00, Br=0.
REQ-027 Load A=1, B=0, then hold in_valid=0 for 3 cycles while toggling A/B -> D=1, Br=0 held, out_valid=0.
REQ-028 Drive rst_n=0 between clock edges during a valid stream -> D, Br, out_valid (and borrow_cnt) go to 0 before the next edge; first result after release appears 1 cycle after first accepted input.
REQ-029 With HALF_SUBTRACTOR_BORROW_CNT_EN, WIDTH=1, apply A=0, B=1 valid for 70000 cycles -> borrow_cnt stops at 16'hFFFF; A=1, B=0 cycles leave it unchanged.

Source files
------------

// File: rtl/half_subtractor_pkg.sv
// Shared constants and helpers for the registered half subtractor.
package half_subtractor_pkg;

  localparam int unsigned HS_DEFAULT_WIDTH = 1;
  localparam int unsigned HS_CNT_WIDTH     = 16;
  localparam logic [HS_CNT_WIDTH-1:0] HS_CNT_SAT = {HS_CNT_WIDTH{1'b1}};

  // Increment that sticks at the saturation value instead of wrapping.
  function automatic logic [HS_CNT_WIDTH-1:0] hs_sat_inc(input logic [HS_CNT_WIDTH-1:0] v);
    return (v == HS_CNT_SAT) ? v : v + HS_CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/half_subtractor_core.sv
// Purely combinational difference/borrow: diff = (a - b) mod 2^WIDTH, borrow = (a < b).
module half_subtractor_core
  import half_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = HS_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] diff_c,
  output logic             borrow_c
);

  logic [WIDTH:0] ext_c;

  // The extra MSB of a zero-extended subtraction is exactly the unsigned borrow.
  always_comb begin
    ext_c    = {1'b0, a_i} - {1'b0, b_i};
    diff_c   = ext_c[WIDTH-1:0];
    borrow_c = ext_c[WIDTH];
  end

endmodule

// File: rtl/half_subtractor.sv
// Registered half subtractor with valid pipe; optional saturating borrow-event
// counter enabled by defining HALF_SUBTRACTOR_BORROW_CNT_EN.
module half_subtractor
  import half_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = HS_DEFAULT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        A,
  input  logic [WIDTH-1:0]        B,
  input  logic                    in_valid,
  output logic [WIDTH-1:0]        D,
  output logic                    Br,
  output logic                    out_valid
`ifdef HALF_SUBTRACTOR_BORROW_CNT_EN
  ,
  output logic [HS_CNT_WIDTH-1:0] borrow_cnt
`endif
);

  logic [WIDTH-1:0] diff_c;
  logic             borrow_c;
  logic [WIDTH-1:0] d_q, d_d;
  logic             br_q, br_d;
  logic             valid_q;

  half_subtractor_core #(.WIDTH(WIDTH)) u_core (
    .a_i      (A),
    .b_i      (B),
    .diff_c   (diff_c),
    .borrow_c (borrow_c)
  );

  // Result only loads on a qualified cycle, so A/B are don't-care otherwise.
  always_comb begin
    d_d  = d_q;
    br_d = br_q;
    if (in_valid) begin
      d_d  = diff_c;
      br_d = borrow_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q     <= '0;
      br_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      d_q     <= d_d;
      br_q    <= br_d;
      valid_q <= in_valid;
    end
  end

  assign D         = d_q;
  assign Br        = br_q;
  assign out_valid = valid_q;

`ifdef HALF_SUBTRACTOR_BORROW_CNT_EN
  logic [HS_CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (in_valid && borrow_c) cnt_d = hs_sat_inc(cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign borrow_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_half_subtractor.sv
// Self-checking bench: WIDTH=1 and WIDTH=8 instances driven in lockstep,
// table vectors plus reset and counter sequences, scoreboard-checked.
module tb_half_subtractor;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       a1, b1;
  logic [7:0] a8, b8;
  logic       d1, br1, ov1;
  logic [7:0] d8;
  logic       br8, ov8;
`ifdef HALF_SUBTRACTOR_BORROW_CNT_EN
  logic [15:0] cnt1, cnt8;
  logic [15:0] cnt1_exp, cnt8_exp;
`endif

  typedef struct {
    logic       d1;
    logic       br1;
    logic [7:0] d8;
    logic       br8;
  } exp_t;

  typedef struct {
    logic       v;
    logic       a1, b1;
    logic [7:0] a8, b8;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  exp_t hold;
  int   checks   = 0;
  int   failures = 0;

  half_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .in_valid(in_valid),
    .D(d1), .Br(br1), .out_valid(ov1)
`ifdef HALF_SUBTRACTOR_BORROW_CNT_EN
    , .borrow_cnt(cnt1)
`endif
  );

  half_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .in_valid(in_valid),
    .D(d8), .Br(br8), .out_valid(ov8)
`ifdef HALF_SUBTRACTOR_BORROW_CNT_EN
    , .borrow_cnt(cnt8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic ia1, ib1, input logic [7:0] ia8, ib8);
    exp_t e;
    e.d1  = ia1 ^ ib1;
    e.br1 = ~ia1 & ib1;
    e.d8  = 8'(ia8 - ib8);
    e.br8 = (ia8 < ib8);
    return e;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic check_outputs(input logic cap);
    chk("out_valid_w1", 32'(ov1), 32'(cap));
    chk("out_valid_w8", 32'(ov8), 32'(cap));
    if (cap) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard_empty actual=0 required=1");
      end else begin
        hold = sb.pop_front();
      end
    end
    chk("d_w1",  32'(d1),  32'(hold.d1));
    chk("br_w1", 32'(br1), 32'(hold.br1));
    chk("d_w8",  32'(d8),  32'(hold.d8));
    chk("br_w8", 32'(br8), 32'(hold.br8));
`ifdef HALF_SUBTRACTOR_BORROW_CNT_EN
    chk("borrow_cnt_w1", 32'(cnt1), 32'(cnt1_exp));
    chk("borrow_cnt_w8", 32'(cnt8), 32'(cnt8_exp));
`endif
  endtask

  // Drive one cycle at the falling edge, check #1 after the rising edge.
  task automatic step(input logic v, input logic ia1, ib1, input logic [7:0] ia8, ib8,
                      input exp_t e);
    logic cap;
    @(negedge clk);
    in_valid = v; a1 = ia1; b1 = ib1; a8 = ia8; b8 = ib8;
    cap = v && rst_n;
    if (cap) sb.push_back(e);
`ifdef HALF_SUBTRACTOR_BORROW_CNT_EN
    if (cap && (ia1 < ib1)) cnt1_exp = sat_inc(cnt1_exp);
    if (cap && (ia8 < ib8)) cnt8_exp = sat_inc(cnt8_exp);
`endif
    @(posedge clk);
    #1;
    check_outputs(cap);
  endtask

  task automatic clear_model();
    sb.delete();
    hold = '{d1: 1'b0, br1: 1'b0, d8: 8'h00, br8: 1'b0};
`ifdef HALF_SUBTRACTOR_BORROW_CNT_EN
    cnt1_exp = 16'h0000;
    cnt8_exp = 16'h0000;
`endif
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{v:1, a1:0, b1:0, a8:8'h05, b8:8'h07, e:'{d1:0, br1:0, d8:8'hFE, br8:1}};
    vecs[1] = '{v:1, a1:0, b1:1, a8:8'h80, b8:8'h80, e:'{d1:1, br1:1, d8:8'h00, br8:0}};
    vecs[2] = '{v:1, a1:1, b1:0, a8:8'h00, b8:8'hFF, e:'{d1:1, br1:0, d8:8'h01, br8:1}};
    vecs[3] = '{v:1, a1:1, b1:1, a8:8'hFF, b8:8'h00, e:'{d1:0, br1:0, d8:8'hFF, br8:0}};
    vecs[4] = '{v:1, a1:1, b1:0, a8:8'h10, b8:8'h01, e:'{d1:1, br1:0, d8:8'h0F, br8:0}};
    vecs[5] = '{v:0, a1:0, b1:1, a8:8'hAA, b8:8'h55, e:'{d1:0, br1:0, d8:8'h00, br8:0}};
    vecs[6] = '{v:0, a1:1, b1:1, a8:8'h33, b8:8'h77, e:'{d1:0, br1:0, d8:8'h00, br8:0}};
    vecs[7] = '{v:0, a1:0, b1:0, a8:8'hC3, b8:8'hFE, e:'{d1:0, br1:0, d8:8'h00, br8:0}};
    vecs[8] = '{v:1, a1:0, b1:0, a8:8'h7F, b8:8'h80, e:'{d1:0, br1:0, d8:8'hFF, br8:1}};

    rst_n = 1'b1; in_valid = 1'b0; a1 = 1'b0; b1 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    clear_model();
    #1 rst_n = 1'b0;
    #1;
    check_outputs(1'b0);

    // Valid inputs while in reset must not be captured.
    step(1'b1, 1'b0, 1'b1, 8'h01, 8'h02, model(1'b0, 1'b1, 8'h01, 8'h02));
    step(1'b1, 1'b1, 1'b0, 8'h09, 8'h02, model(1'b1, 1'b0, 8'h09, 8'h02));
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;

    // Back-to-back table vectors, including a 3-cycle hold with toggling inputs.
    for (int i = 0; i < 9; i++)
      step(vecs[i].v, vecs[i].a1, vecs[i].b1, vecs[i].a8, vecs[i].b8, vecs[i].e);
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, vecs[0].e);

    // Random valid/idle mix against the model.
    for (int i = 0; i < 20; i++) begin
      logic        rv, ra1, rb1;
      logic [7:0]  ra8, rb8;
      rv  = 1'($urandom_range(0, 3) != 0);
      ra1 = 1'($urandom_range(0, 1)); rb1 = 1'($urandom_range(0, 1));
      ra8 = 8'($urandom_range(0, 255)); rb8 = 8'($urandom_range(0, 255));
      step(rv, ra1, rb1, ra8, rb8, model(ra1, rb1, ra8, rb8));
    end

    // Asynchronous reset between edges during a valid stream.
    step(1'b1, 1'b0, 1'b1, 8'h00, 8'hFF, model(1'b0, 1'b1, 8'h00, 8'hFF));
    @(negedge clk);
    in_valid = 1'b1; a1 = 1'b1; b1 = 1'b0; a8 = 8'h20; b8 = 8'h10;
    #2 rst_n = 1'b0;
    #1;
    clear_model();
    check_outputs(1'b0);
    @(posedge clk);
    #1;
    check_outputs(1'b0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    step(1'b0, 1'b1, 1'b1, 8'h44, 8'h45, model(1'b1, 1'b1, 8'h44, 8'h45));
    step(1'b1, 1'b0, 1'b1, 8'h05, 8'h07, model(1'b0, 1'b1, 8'h05, 8'h07));
    step(1'b1, 1'b1, 1'b1, 8'h80, 8'h80, model(1'b1, 1'b1, 8'h80, 8'h80));

`ifdef HALF_SUBTRACTOR_BORROW_CNT_EN
    // Saturate the borrow counters, then confirm non-borrow cycles leave them alone.
    @(negedge clk);
    in_valid = 1'b1; a1 = 1'b0; b1 = 1'b1; a8 = 8'h00; b8 = 8'h01;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    sb.delete();
    hold     = model(1'b0, 1'b1, 8'h00, 8'h01);
    cnt1_exp = 16'hFFFF;
    cnt8_exp = 16'hFFFF;
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, hold);
    step(1'b1, 1'b0, 1'b1, 8'h00, 8'h01, model(1'b0, 1'b1, 8'h00, 8'h01));
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 1'b0, 8'h01, 8'h00, model(1'b1, 1'b0, 8'h01, 8'h00));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
